flash_command_sequencer: RTL and testbench
==========================================

Name: flash_command_sequencer

Overview:
- Sequences JEDEC-style command cycles to the on-board Kickstart FLASH pair during a programming session: unlock writes, word program, sector/chip erase, read-array reset.
- Completion is detected by DQ6 toggle polling with a DQ5 fault check and a cycle timeout.
- A single host requester (programming interface) submits one command at a time through a valid/ready handshake.
- Drives the FLASH_WR/FLASH_RD strobes, address and data exclusively while BUSY=1.

Parameters:
WE_PULSE_CYCLES, 4, clocks FLASH_WR held low per bus write (>=1)
RD_CYCLES, 3, clocks FLASH_RD held low per bus read (>=1); data sampled on last low cycle
TIMEOUT_CYCLES, 1048576, max clocks spent in polling before declaring error
ADDR_WIDTH, 19, FLASH word-address width (512K words = 1 MB)

Ports:
MB_CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE; command accepted when CMD_VALID&CMD_READY
CMD_OP  in  2  00 read-array reset, 01 word program, 10 sector erase, 11 chip erase
CMD_ADDR  in  ADDR_WIDTH  word address (program target / sector address)
CMD_DATA  in  16  program data
BUSY  out  1  high from cycle after accept until DONE cycle inclusive
DONE  out  1  one-cycle completion pulse
ERROR  out  1  status; valid in DONE cycle, held until next accept
FLASH_A  out  ADDR_WIDTH  FLASH word address
FLASH_DQ_OUT  out  16  write data
FLASH_DQ_OE  out  1  high while driving FLASH_DQ_OUT
FLASH_DQ_IN  in  16  read data from FLASH
FLASH_WR  out  2  active-low write strobes {upper,lower}; both asserted together
FLASH_RD  out  2  active-low read strobes {upper,lower}; both asserted together

Behaviour:
- Reset (RESET=0 at edge, any state incl. mid-pulse): state IDLE; CMD_READY=1; BUSY=0, DONE=0, ERROR=0; FLASH_WR=11, FLASH_RD=11, FLASH_DQ_OE=0, FLASH_A=0, FLASH_DQ_OUT=0. No completion of the interrupted sequence; host must issue OP 00 afterwards.
- Accept: CMD_OP/ADDR/DATA latched at the accept edge; ERROR cleared; first bus write SETUP starts next cycle. CMD_VALID while busy is ignored.
- Bus write, WE_PULSE_CYCLES+2 clocks:
  - SETUP: 1 clock; A/DQ valid, OE=1, WR=11.
  - PULSE: WE_PULSE_CYCLES clocks; WR=00.
  - HOLD: 1 clock; WR=11, A/DQ/OE unchanged.
  - Next write's SETUP follows immediately.
- Bus read, RD_CYCLES+1 clocks: OE=0; RD=00 for RD_CYCLES clocks, sample FLASH_DQ_IN at the edge ending the last low clock; then 1 recovery clock with RD=11.
- Sequences (addr/data, word mode):
  - OP00: xxx/F0 (A=CMD_ADDR); no poll.
  - OP01: 555/AA, 2AA/55, 555/A0, ADDR/CMD_DATA.
  - OP10: 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, ADDR/0030.
  - OP11: as OP10 but last write 555/0010.
  - FLASH_DQ_OUT upper byte 00 for command writes.
- Poll (OP01/10/11), A=CMD_ADDR (chip erase: A=0):
  - Read pair R1, R2. If R1[6]==R2[6], the operation is done.
    - OP01: ERROR=1 if R2!=CMD_DATA, else 0.
    - Erase: ERROR=1 if R2!=FFFF, else 0.
  - Else if R2[5]=1: one more pair R3, R4. If R3[6]==R4[6], evaluate as done using R4. Else fault.
  - Else: repeat pair.
- Timeout counter:
  - Cleared on poll entry; increments each poll clock.
  - Reaching TIMEOUT_CYCLES-1 ends the current read, then takes the fault path.
- Fault path: one bus write xxx/F0, then DONE with ERROR=1.
- DONE asserts 1 clock after final HOLD/recovery; state returns to IDLE the next clock with CMD_READY=1.
- Address/data states are held stable across each full write; no glitches on FLASH_WR/RD (registered outputs).

Test Plan:
- RESET=0 for 2 clocks mid-PULSE of an erase -> next clock FLASH_WR=11, FLASH_RD=11, OE=0, CMD_READY=1, BUSY=0.
- OP01 ADDR=01234 DATA=BEEF; model toggles DQ6 for 3 pairs then returns BEEF -> writes 555/00AA, 2AA/0055, 555/00A0, 01234/BEEF; WR=00 exactly 4 clocks each; write 1 SETUP is the clock after accept; DONE=1, ERROR=0.
- OP10 ADDR=40000; model returns FFFF stable -> six writes ending 40000/0030, one read pair, DONE, ERROR=0.
- OP01 with model toggling DQ6 and DQ5=1 -> extra read pair still toggling -> write xxx/00F0, DONE, ERROR=1.
- TIMEOUT_CYCLES=64, OP11, model toggles forever with DQ5=0 -> F0 write, DONE with ERROR=1 within 64+RD_CYCLES+1+WE_PULSE_CYCLES+3 clocks of poll entry.
- OP01 DATA=1234, model stable at 1230 -> DONE, ERROR=1; CMD_VALID held high during BUSY -> no second accept until CMD_READY returns.

Source files
------------

// File: rtl/flash_command_sequencer_if.sv
// Host command handshake and FLASH bus of the command sequencer.
// The slave modport is the sequencer side; the master modport is the host/FLASH side.
interface flash_command_sequencer_if #(
   parameter int ADDR_WIDTH = 19
);
   logic                  CMD_VALID;
   logic                  CMD_READY;
   logic [1:0]            CMD_OP;
   logic [ADDR_WIDTH-1:0] CMD_ADDR;
   logic [15:0]           CMD_DATA;
   logic                  BUSY;
   logic                  DONE;
   logic                  ERROR;
   logic [ADDR_WIDTH-1:0] FLASH_A;
   logic [15:0]           FLASH_DQ_OUT;
   logic                  FLASH_DQ_OE;
   logic [15:0]           FLASH_DQ_IN;
   logic [1:0]            FLASH_WR;
   logic [1:0]            FLASH_RD;

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, FLASH_DQ_IN,
      output CMD_READY, BUSY, DONE, ERROR,
             FLASH_A, FLASH_DQ_OUT, FLASH_DQ_OE, FLASH_WR, FLASH_RD
   );

   modport master (
      output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, FLASH_DQ_IN,
      input  CMD_READY, BUSY, DONE, ERROR,
             FLASH_A, FLASH_DQ_OUT, FLASH_DQ_OE, FLASH_WR, FLASH_RD
   );
endinterface

// File: rtl/flash_command_sequencer.sv
// JEDEC command sequencer for the Kickstart FLASH pair: unlock/program/erase
// write cycles followed by DQ6 toggle polling with DQ5 fault and timeout checks.
module flash_command_sequencer #(
   parameter int WE_PULSE_CYCLES = 4,
   parameter int RD_CYCLES       = 3,
   parameter int TIMEOUT_CYCLES  = 1048576,
   parameter int ADDR_WIDTH      = 19
) (
   input logic                      MB_CLK,
   input logic                      RESET,
   flash_command_sequencer_if.slave bus
);

   localparam int MAX_CYC = (WE_PULSE_CYCLES > RD_CYCLES) ? WE_PULSE_CYCLES : RD_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WE_LAST = CW'(WE_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] A555 = ADDR_WIDTH'(11'h555);
   localparam logic [ADDR_WIDTH-1:0] A2AA = ADDR_WIDTH'(11'h2AA);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_LOW, S_RD_REC, S_DONE
   } state_t;

   state_t                state_reg, state_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic [2:0]            wr_idx_reg, wr_idx_next;
   logic [1:0]            op_reg, op_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [15:0]           data_reg, data_next;
   logic                  rd_idx_reg, rd_idx_next;
   logic                  extra_reg, extra_next;
   logic                  fault_reg, fault_next;
   logic [TW-1:0]         to_cnt_reg, to_cnt_next;
   logic                  r_first6_reg, r_first6_next;
   logic [15:0]           r_second_reg, r_second_next;
   logic                  error_reg, error_next;
   logic [ADDR_WIDTH-1:0] a_reg, a_next;
   logic [15:0]           dq_reg, dq_next;
   logic [1:0]            wr_reg, wr_next;
   logic [1:0]            rd_reg, rd_next;
   logic                  oe_reg, oe_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;
   logic                  ready_reg, ready_next;

   logic [2:0]            last_idx;
   logic [ADDR_WIDTH-1:0] poll_addr;
   logic [ADDR_WIDTH+15:0] seq_word;

   // Address/data of write number idx within the command's unlock sequence.
   function automatic logic [ADDR_WIDTH+15:0] seq_lookup(
      input logic [1:0]            op,
      input logic [2:0]            idx,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [15:0]           data
   );
      logic [ADDR_WIDTH-1:0] a;
      logic [15:0]           d;
      a = addr;
      d = 16'h00F0;
      if (op != 2'b00) begin
         case (idx)
            3'd0:    begin a = A555; d = 16'h00AA; end
            3'd1:    begin a = A2AA; d = 16'h0055; end
            3'd2:    begin a = A555; d = (op == 2'b01) ? 16'h00A0 : 16'h0080; end
            3'd3:    begin
               if (op == 2'b01) begin a = addr; d = data; end
               else             begin a = A555; d = 16'h00AA; end
            end
            3'd4:    begin a = A2AA; d = 16'h0055; end
            default: begin
               if (op == 2'b11) begin a = A555; d = 16'h0010; end
               else             begin a = addr; d = 16'h0030; end
            end
         endcase
      end
      return {a, d};
   endfunction

   assign last_idx  = (op_reg == 2'b00) ? 3'd0 : (op_reg == 2'b01) ? 3'd3 : 3'd5;
   assign poll_addr = (op_reg == 2'b11) ? '0 : addr_reg;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      wr_idx_next   = wr_idx_reg;
      op_next       = op_reg;
      addr_next     = addr_reg;
      data_next     = data_reg;
      rd_idx_next   = rd_idx_reg;
      extra_next    = extra_reg;
      fault_next    = fault_reg;
      to_cnt_next   = to_cnt_reg;
      r_first6_next = r_first6_reg;
      r_second_next = r_second_reg;
      error_next    = error_reg;
      a_next        = a_reg;
      dq_next       = dq_reg;
      seq_word      = '0;

      case (state_reg)
         S_IDLE: begin
            if (bus.CMD_VALID) begin
               op_next     = bus.CMD_OP;
               addr_next   = bus.CMD_ADDR;
               data_next   = bus.CMD_DATA;
               error_next  = 1'b0;
               fault_next  = 1'b0;
               extra_next  = 1'b0;
               wr_idx_next = 3'd0;
               state_next  = S_WR_SETUP;
            end
         end
         S_WR_SETUP: begin
            cnt_next   = '0;
            state_next = S_WR_PULSE;
         end
         S_WR_PULSE: begin
            if (cnt_reg == WE_LAST) state_next = S_WR_HOLD;
            else                    cnt_next   = cnt_reg + 1'b1;
         end
         S_WR_HOLD: begin
            if (fault_reg) begin
               error_next = 1'b1;
               state_next = S_DONE;
            end else if (wr_idx_reg != last_idx) begin
               wr_idx_next = wr_idx_reg + 1'b1;
               state_next  = S_WR_SETUP;
            end else if (op_reg == 2'b00) begin
               error_next = 1'b0;
               state_next = S_DONE;
            end else begin
               cnt_next    = '0;
               rd_idx_next = 1'b0;
               to_cnt_next = '0;
               a_next      = poll_addr;
               state_next  = S_RD_LOW;
            end
         end
         S_RD_LOW: begin
            if (to_cnt_reg != TO_MAX) to_cnt_next = to_cnt_reg + 1'b1;
            if (cnt_reg == RD_LAST) begin
               if (rd_idx_reg) r_second_next = bus.FLASH_DQ_IN;
               else            r_first6_next = bus.FLASH_DQ_IN[6];
               state_next = S_RD_REC;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_RD_REC: begin
            if (to_cnt_reg != TO_MAX) to_cnt_next = to_cnt_reg + 1'b1;
            cnt_next = '0;
            // A timeout ends polling at the end of whichever read hit it.
            if (to_cnt_reg == TO_MAX) begin
               fault_next = 1'b1;
               state_next = S_WR_SETUP;
            end else if (!rd_idx_reg) begin
               rd_idx_next = 1'b1;
               state_next  = S_RD_LOW;
            end else begin
               rd_idx_next = 1'b0;
               if (r_first6_reg == r_second_reg[6]) begin
                  error_next = (op_reg == 2'b01) ? (r_second_reg != data_reg)
                                                 : (r_second_reg != 16'hFFFF);
                  state_next = S_DONE;
               end else if (extra_reg) begin
                  fault_next = 1'b1;
                  state_next = S_WR_SETUP;
               end else begin
                  extra_next = r_second_reg[5];
                  state_next = S_RD_LOW;
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if (state_next == S_WR_SETUP) begin
         if (fault_next) begin
            a_next  = poll_addr;
            dq_next = 16'h00F0;
         end else begin
            seq_word = seq_lookup(op_next, wr_idx_next, addr_next, data_next);
            a_next   = seq_word[ADDR_WIDTH+15:16];
            dq_next  = seq_word[15:0];
         end
      end

      wr_next    = (state_next == S_WR_PULSE) ? 2'b00 : 2'b11;
      rd_next    = (state_next == S_RD_LOW)   ? 2'b00 : 2'b11;
      oe_next    = (state_next == S_WR_SETUP) || (state_next == S_WR_PULSE) ||
                   (state_next == S_WR_HOLD);
      busy_next  = (state_next != S_IDLE);
      done_next  = (state_next == S_DONE);
      ready_next = (state_next == S_IDLE);
   end

   always_ff @(posedge MB_CLK) begin
      if (!RESET) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         wr_idx_reg   <= '0;
         op_reg       <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         rd_idx_reg   <= 1'b0;
         extra_reg    <= 1'b0;
         fault_reg    <= 1'b0;
         to_cnt_reg   <= '0;
         r_first6_reg <= 1'b0;
         r_second_reg <= '0;
         error_reg    <= 1'b0;
         a_reg        <= '0;
         dq_reg       <= '0;
         wr_reg       <= 2'b11;
         rd_reg       <= 2'b11;
         oe_reg       <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         ready_reg    <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         wr_idx_reg   <= wr_idx_next;
         op_reg       <= op_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
         rd_idx_reg   <= rd_idx_next;
         extra_reg    <= extra_next;
         fault_reg    <= fault_next;
         to_cnt_reg   <= to_cnt_next;
         r_first6_reg <= r_first6_next;
         r_second_reg <= r_second_next;
         error_reg    <= error_next;
         a_reg        <= a_next;
         dq_reg       <= dq_next;
         wr_reg       <= wr_next;
         rd_reg       <= rd_next;
         oe_reg       <= oe_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         ready_reg    <= ready_next;
      end
   end

   assign bus.CMD_READY    = ready_reg;
   assign bus.BUSY         = busy_reg;
   assign bus.DONE         = done_reg;
   assign bus.ERROR        = error_reg;
   assign bus.FLASH_A      = a_reg;
   assign bus.FLASH_DQ_OUT = dq_reg;
   assign bus.FLASH_DQ_OE  = oe_reg;
   assign bus.FLASH_WR     = wr_reg;
   assign bus.FLASH_RD     = rd_reg;

endmodule

// File: tb/tb_flash_command_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus writes and completions,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_flash_command_sequencer;

   typedef struct {
      bit          is_done;
      bit          addr_dc;
      logic [18:0] addr;
      logic [15:0] data;
      bit          err;
      int          reads;
   } exp_t;

   logic MB_CLK;
   logic RESET;
   flash_command_sequencer_if #(.ADDR_WIDTH(19)) bus ();

   flash_command_sequencer #(
      .WE_PULSE_CYCLES(4),
      .RD_CYCLES      (3),
      .TIMEOUT_CYCLES (64),
      .ADDR_WIDTH     (19)
   ) dut (
      .MB_CLK(MB_CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b1;
   int          accept_cnt = 0;
   int          model_mode = 0;
   logic [15:0] model_val  = 16'hFFFF;
   int          rd_k = 0;
   bit          rd_was_low = 1'b0;

   initial begin
      MB_CLK = 1'b0;
      forever #5 MB_CLK = ~MB_CLK;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // FLASH model: read k of the current command, DQ6 toggling per mode.
   initial begin
      forever begin
         @(negedge MB_CLK);
         if (!bus.BUSY) begin
            rd_k = 0;
            rd_was_low = 1'b0;
         end else if (bus.FLASH_RD == 2'b00) begin
            rd_was_low = 1'b1;
         end else if (rd_was_low) begin
            rd_k++;
            rd_was_low = 1'b0;
         end
      end
   end

   always_comb begin
      logic [15:0] tog;
      tog = rd_k[0] ? 16'h0040 : 16'h0000;
      case (model_mode)
         1:       bus.FLASH_DQ_IN = (rd_k < 6) ? tog : model_val;
         2:       bus.FLASH_DQ_IN = tog | 16'h0020;
         3:       bus.FLASH_DQ_IN = tog;
         default: bus.FLASH_DQ_IN = model_val;
      endcase
   end

   // Monitor: one scoreboard pop per completed bus write and per DONE pulse.
   initial begin
      int   pulse_len;
      int   rd_cnt;
      bit   rd_low;
      exp_t e;
      pulse_len = 0;
      rd_cnt    = 0;
      rd_low    = 1'b0;
      forever begin
         @(negedge MB_CLK);
         if (!RESET || !mon_en) begin
            pulse_len = 0;
            rd_cnt    = 0;
            rd_low    = 1'b0;
         end else begin
            if (bus.CMD_VALID && bus.CMD_READY) accept_cnt++;
            if (bus.FLASH_WR == 2'b00) begin
               pulse_len++;
            end else if (pulse_len != 0) begin
               $display("write A=%05h DQ=%04h pulse=%0d", bus.FLASH_A, bus.FLASH_DQ_OUT, pulse_len);
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("write_expected_kind", {31'd0, e.is_done}, 0);
                  if (!e.addr_dc) check("write_addr", bus.FLASH_A, e.addr);
                  check("write_data", bus.FLASH_DQ_OUT, e.data);
                  check("write_pulse_len", pulse_len, 4);
                  check("write_oe_hold", bus.FLASH_DQ_OE, 1);
               end
               pulse_len = 0;
            end
            if (bus.FLASH_RD == 2'b00) begin
               rd_low = 1'b1;
            end else if (rd_low) begin
               rd_cnt++;
               rd_low = 1'b0;
            end
            if (bus.DONE) begin
               $display("done ERROR=%0d reads=%0d", bus.ERROR, rd_cnt);
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_expected_kind", {31'd0, e.is_done}, 1);
                  check("done_error", bus.ERROR, e.err);
                  check("done_read_count", rd_cnt, e.reads);
               end
               rd_cnt = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge MB_CLK);
      #1;
   endtask

   task automatic push_w(input logic [18:0] a, input logic [15:0] d, input bit dc);
      exp_t e;
      e.is_done = 1'b0; e.addr_dc = dc; e.addr = a; e.data = d; e.err = 1'b0; e.reads = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_d(input bit err, input int reads);
      exp_t e;
      e.is_done = 1'b1; e.addr_dc = 1'b0; e.addr = '0; e.data = '0; e.err = err; e.reads = reads;
      exp_q.push_back(e);
   endtask

   task automatic push_prog(input logic [18:0] a, input logic [15:0] d);
      push_w(19'h555, 16'h00AA, 0);
      push_w(19'h2AA, 16'h0055, 0);
      push_w(19'h555, 16'h00A0, 0);
      push_w(a, d, 0);
   endtask

   task automatic push_erase(input logic [18:0] a, input bit chip);
      push_w(19'h555, 16'h00AA, 0);
      push_w(19'h2AA, 16'h0055, 0);
      push_w(19'h555, 16'h0080, 0);
      push_w(19'h555, 16'h00AA, 0);
      push_w(19'h2AA, 16'h0055, 0);
      if (chip) push_w(19'h555, 16'h0010, 0);
      else      push_w(a, 16'h0030, 0);
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [18:0] a, input logic [15:0] d, input bit hold);
      int n;
      n = 0;
      while (!bus.CMD_READY && n < 200) begin
         tick();
         n++;
      end
      check("ready_before_cmd", bus.CMD_READY, 1);
      bus.CMD_OP    = op;
      bus.CMD_ADDR  = a;
      bus.CMD_DATA  = d;
      bus.CMD_VALID = 1'b1;
      tick();
      check("busy_after_accept", bus.BUSY, 1);
      check("setup_oe_after_accept", bus.FLASH_DQ_OE, 1);
      check("setup_wr_after_accept", bus.FLASH_WR, 2'b11);
      check("error_cleared_on_accept", bus.ERROR, 0);
      if (!hold) bus.CMD_VALID = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      int  first;
      int  i;
      bit  seen;
      first = -1;
      seen  = 1'b0;
      lat   = -1;
      for (i = 0; i < 3000; i++) begin
         if (bus.FLASH_RD == 2'b00 && first < 0) first = i;
         if (bus.DONE) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) check("done_within_budget", 0, 1);
      else if (first >= 0) lat = i - first;
   endtask

   initial begin
      int lat;
      int acc0;
      int n;
      RESET         = 1'b0;
      bus.CMD_VALID = 1'b0;
      bus.CMD_OP    = 2'b00;
      bus.CMD_ADDR  = '0;
      bus.CMD_DATA  = '0;
      tick(); tick(); tick();
      check("rst_ready", bus.CMD_READY, 1);
      check("rst_busy", bus.BUSY, 0);
      check("rst_done", bus.DONE, 0);
      check("rst_error", bus.ERROR, 0);
      check("rst_wr", bus.FLASH_WR, 2'b11);
      check("rst_rd", bus.FLASH_RD, 2'b11);
      check("rst_oe", bus.FLASH_DQ_OE, 0);
      check("rst_a", bus.FLASH_A, 0);
      check("rst_dq", bus.FLASH_DQ_OUT, 0);
      RESET = 1'b1;
      tick();

      // Reset in the middle of an erase write pulse.
      mon_en = 1'b0;
      model_mode = 0; model_val = 16'hFFFF;
      send_cmd(2'b10, 19'h40000, 16'h0000, 0);
      n = 0;
      while (bus.FLASH_WR != 2'b00 && n < 50) begin
         tick();
         n++;
      end
      check("wr_low_before_reset", bus.FLASH_WR, 2'b00);
      tick();
      RESET = 1'b0;
      tick();
      check("midrst_wr", bus.FLASH_WR, 2'b11);
      check("midrst_rd", bus.FLASH_RD, 2'b11);
      check("midrst_oe", bus.FLASH_DQ_OE, 0);
      check("midrst_ready", bus.CMD_READY, 1);
      check("midrst_busy", bus.BUSY, 0);
      check("midrst_a", bus.FLASH_A, 0);
      tick();
      RESET = 1'b1;
      mon_en = 1'b1;
      tick();

      // Read-array reset after the abort.
      push_w(19'h12345, 16'h00F0, 0);
      push_d(0, 0);
      send_cmd(2'b00, 19'h12345, 16'h0000, 0);
      wait_done(lat);
      tick();

      // Program, DQ6 toggles for three pairs then data settles.
      model_mode = 1; model_val = 16'hBEEF;
      push_prog(19'h01234, 16'hBEEF);
      push_d(0, 8);
      send_cmd(2'b01, 19'h01234, 16'hBEEF, 0);
      wait_done(lat);
      tick();

      // Sector erase, already erased.
      model_mode = 0; model_val = 16'hFFFF;
      push_erase(19'h40000, 0);
      push_d(0, 2);
      send_cmd(2'b10, 19'h40000, 16'h0000, 0);
      wait_done(lat);
      tick();

      // Program with DQ5 set and DQ6 still toggling on the extra pair.
      model_mode = 2;
      push_prog(19'h00100, 16'h5A5A);
      push_w(19'h00000, 16'h00F0, 1);
      push_d(1, 4);
      send_cmd(2'b01, 19'h00100, 16'h5A5A, 0);
      wait_done(lat);
      tick();

      // Chip erase that never completes: timeout fault.
      model_mode = 3;
      push_erase(19'h00000, 1);
      push_w(19'h00000, 16'h00F0, 1);
      push_d(1, 16);
      send_cmd(2'b11, 19'h3FFFF, 16'h0000, 0);
      wait_done(lat);
      n_checks++;
      if (lat < 0 || lat > 64 + 3 + 1 + 4 + 3) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d clocks, required 0..%0d", lat, 64 + 3 + 1 + 4 + 3);
      end
      tick();

      // Program verify mismatch, with CMD_VALID held through BUSY.
      model_mode = 0; model_val = 16'h1230;
      push_prog(19'h7FFFF, 16'h1234);
      push_d(1, 2);
      acc0 = accept_cnt;
      send_cmd(2'b01, 19'h7FFFF, 16'h1234, 1);
      wait_done(lat);
      tick();
      bus.CMD_VALID = 1'b0;
      check("ready_back_in_idle", bus.CMD_READY, 1);
      check("error_held_in_idle", bus.ERROR, 1);
      check("single_accept_while_busy", accept_cnt - acc0, 1);

      push_w(19'h00000, 16'h00F0, 0);
      push_d(0, 0);
      send_cmd(2'b00, 19'h00000, 16'h0000, 0);
      wait_done(lat);
      tick(); tick();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
